// File: rtl/pic8259_pkg.sv
// pic8259_pkg: shared control-state encoding, CALL opcode and one-hot index helper for the 8259A core.
package pic8259_pkg;

    typedef enum logic [2:0] {
        READY = 3'b000,
        ACK1  = 3'b001,
        ACK2  = 3'b010,
        ACK3  = 3'b011
    } control_state_t;

    localparam logic [7:0] CALL_OPCODE = 8'hCD;

    function automatic logic [2:0] bit2num(input logic [7:0] one_hot);
        logic [2:0] num;
        num = 3'd0;
        for (int i = 0; i < 8; i++)
            if (one_hot[i]) num = i[2:0];
        return num;
    endfunction

endpackage

// File: rtl/inta_edge_detector.sv
// inta_edge_detector: registers INTA and flags its falling and rising edges; idles high after reset.
module inta_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic interrupt_acknowledge_n,
    output logic fall,
    output logic rise
);

    logic inta_prev;

    always_ff @(posedge clock)
        inta_prev <= reset ? 1'b1 : interrupt_acknowledge_n;

    assign fall = inta_prev & ~interrupt_acknowledge_n;
    assign rise = ~inta_prev & interrupt_acknowledge_n;

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: counts INTA pulses, latches the acknowledged level and drives vector/CALL bytes.
// ACK_8080_MODE_EN adds the 8080/85 three-pulse CALL sequence; without it only the 8086 sequence exists.
module interrupt_ack_sequencer
    import pic8259_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_acknowledge_n,
    input  logic        initialization_pulse,
    input  logic        mode_8086,
    input  logic        call_address_interval_4,
    input  logic [10:0] interrupt_vector_address,
    input  logic [7:0]  highest_level_request,
    input  logic        cascade_output_ack_2_3,
    output logic [2:0]  control_state,
    output logic [7:0]  acknowledge_interrupt,
    output logic        latch_in_service,
    output logic        end_of_acknowledge_sequence,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_enable
);

    control_state_t state, next_state;
    logic [7:0] next_ack, byte_sel, next_data;
    logic [2:0] lvl;
    logic fall, rise, m86, next_lis, next_eoa, byte_en, next_en;

    inta_edge_detector u_edge (
        .clock                  (clock),
        .reset                  (reset),
        .interrupt_acknowledge_n(interrupt_acknowledge_n),
        .fall                   (fall),
        .rise                   (rise)
    );

`ifdef ACK_8080_MODE_EN
    assign m86 = mode_8086;
`else
    logic unused_8080;
    assign m86 = 1'b1;
    assign unused_8080 = ^{mode_8086, call_address_interval_4, interrupt_vector_address[2:0]};
`endif

    always_comb begin
        next_state = state;
        next_ack = acknowledge_interrupt;
        next_lis = 1'b0;
        next_eoa = 1'b0;
        case (state)
            READY: if (fall) begin
                next_state = ACK1;
                next_ack = |highest_level_request ? highest_level_request : 8'h80;
                next_lis = 1'b1;
            end
            ACK1: if (fall) next_state = ACK2;
            ACK2: if (m86 && rise) begin
                next_state = READY;
                next_eoa = 1'b1;
            end
`ifdef ACK_8080_MODE_EN
            else if (!m86 && fall) next_state = ACK3;
            ACK3: if (rise) begin
                next_state = READY;
                next_eoa = 1'b1;
            end
`endif
            default: next_state = READY;
        endcase
        if (initialization_pulse) begin
            next_state = READY;
            next_ack = 8'h00;
            next_lis = 1'b0;
            next_eoa = 1'b0;
        end
    end

    // Byte for the state being entered, driven for as long as INTA stays low.
    assign lvl = bit2num(next_ack);

    always_comb begin
        byte_en = 1'b0;
        byte_sel = 8'h00;
        case (next_state)
            ACK1: begin
                byte_en = !m86;
                byte_sel = CALL_OPCODE;
            end
            ACK2: begin
                byte_en = cascade_output_ack_2_3;
`ifdef ACK_8080_MODE_EN
                byte_sel = m86 ? {interrupt_vector_address[10:6], lvl}
                         : call_address_interval_4 ? {interrupt_vector_address[2:0], lvl, 2'b00}
                         : {interrupt_vector_address[2:1], lvl, 3'b000};
`else
                byte_sel = {interrupt_vector_address[10:6], lvl};
`endif
            end
`ifdef ACK_8080_MODE_EN
            ACK3: begin
                byte_en = cascade_output_ack_2_3;
                byte_sel = interrupt_vector_address[10:3];
            end
`endif
            default: byte_en = 1'b0;
        endcase
    end

    assign next_en = ~interrupt_acknowledge_n & byte_en & ~initialization_pulse;
    assign next_data = next_en ? byte_sel : 8'h00;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= READY;
            acknowledge_interrupt <= 8'h00;
            latch_in_service <= 1'b0;
            end_of_acknowledge_sequence <= 1'b0;
            data_bus_out <= 8'h00;
            data_bus_out_enable <= 1'b0;
        end else begin
            state <= next_state;
            acknowledge_interrupt <= next_ack;
            latch_in_service <= next_lis;
            end_of_acknowledge_sequence <= next_eoa;
            data_bus_out <= next_data;
            data_bus_out_enable <= next_en;
        end
    end

    assign control_state = state;

endmodule
